comb_lut_sweep: RTL and testbench

//  Parametrised, registered successor to the 3-input combinational function block.

---
 rtl/comb_lut_sweep_if.sv | 27 ++
 rtl/comb_lut_sweep.sv | 106 ++++++++++
 tb/tb_comb_lut_sweep.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/comb_lut_sweep_if.sv
// Function/sweep bus of comb_lut_sweep: evaluation inputs, truth-table load,
// sweep control and the registered result/status outputs.
interface comb_lut_sweep_if #(
  parameter int N_INPUTS = 3
);
  localparam int LUT_W = 1 << N_INPUTS;

  logic [N_INPUTS-1:0] i_w_in;
  logic                i_w_load;
  logic [LUT_W-1:0]    i_w_lut_data;
  logic                i_w_start;
  logic                o_w_out;
  logic                o_w_busy;
  logic                o_w_done;
  logic [N_INPUTS:0]   o_w_ones_count;
  logic [N_INPUTS-1:0] o_w_sweep_idx;

  modport master (
    output i_w_in, i_w_load, i_w_lut_data, i_w_start,
    input  o_w_out, o_w_busy, o_w_done, o_w_ones_count, o_w_sweep_idx
  );

  modport slave (
    input  i_w_in, i_w_load, i_w_lut_data, i_w_start,
    output o_w_out, o_w_busy, o_w_done, o_w_ones_count, o_w_sweep_idx
  );
endinterface

// File: rtl/comb_lut_sweep.sv
// Registered N-input boolean function from a loadable truth table, with an
// on-chip sweep that walks every input combination and counts the ones.
module comb_lut_sweep #(
  parameter int                          N_INPUTS = 3,
  parameter logic [(1<<N_INPUTS)-1:0]    LUT_INIT = 8'hE8
) (
  input  logic               i_w_clk,
  input  logic               i_w_reset,
  comb_lut_sweep_if.slave    bus
);
  localparam int LUT_W = 1 << N_INPUTS;
  localparam logic [N_INPUTS-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LUT_W-1:0]    lut_q, lut_d;
  logic [N_INPUTS-1:0] idx_q, idx_d;
  logic [N_INPUTS:0]   acc_q, acc_d;
  logic [N_INPUTS:0]   count_q, count_d;
  logic                out_q, out_d;

  logic eval_bit;
  logic sweep_bit;

  assign eval_bit  = lut_q[bus.i_w_in];
  assign sweep_bit = lut_q[idx_q];

  // NOTE: every variable gets its hold value first so no path through the case leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    lut_d   = lut_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    count_d = count_q;
    out_d   = out_q;

    unique case (state_q)
      ST_IDLE: begin
        // Evaluation always reads the current table, so a same-edge load is seen one cycle later.
        out_d = eval_bit;
        if (bus.i_w_start) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
          acc_d   = '0;
          count_d = '0;
        end else if (bus.i_w_load) begin
          lut_d = bus.i_w_lut_data;
        end
      end

      ST_SWEEP: begin
        out_d = sweep_bit;
        acc_d = acc_q + (N_INPUTS+1)'(sweep_bit);
        idx_d = idx_q + N_INPUTS'(1);
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          count_d = acc_d;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the truth table is one flat register vector, not a RAM, so it is reset to LUT_INIT with the rest of the state.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state_q <= ST_IDLE;
      lut_q   <= LUT_INIT;
      idx_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      out_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      lut_q   <= lut_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  // Status flags come straight from the state register, so they cannot glitch.
  assign bus.o_w_busy       = (state_q == ST_SWEEP);
  assign bus.o_w_done       = (state_q == ST_DONE);
  assign bus.o_w_out        = out_q;
  assign bus.o_w_ones_count = count_q;
  assign bus.o_w_sweep_idx  = idx_q;

  busy_done_exclusive: assert property (
    @(posedge i_w_clk) disable iff (i_w_reset) !(bus.o_w_busy && bus.o_w_done)
  );
endmodule

// File: tb/tb_comb_lut_sweep.sv
// Directed bench for comb_lut_sweep: evaluation, loads, sweeps, abort by
// reset, ignored inputs during a sweep, and a 4-input build.
module tb_comb_lut_sweep;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  comb_lut_sweep_if #(.N_INPUTS(3)) b3 ();
  comb_lut_sweep_if #(.N_INPUTS(4)) b4 ();

  comb_lut_sweep #(.N_INPUTS(3), .LUT_INIT(8'hE8)) u_dut3 (
    .i_w_clk   (clk),
    .i_w_reset (rst),
    .bus       (b3)
  );

  comb_lut_sweep #(.N_INPUTS(4), .LUT_INIT(16'h8117)) u_dut4 (
    .i_w_clk   (clk),
    .i_w_reset (rst),
    .bus       (b4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One start pulse, then the whole sweep checked cycle by cycle against lut/exp_cnt.
  task automatic run_sweep(input string tag, input logic [7:0] lut, input int exp_cnt, input bit noisy);
    b3.i_w_start = 1'b1;
    tick();
    b3.i_w_start = 1'b0;
    b3.i_w_load  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_busy%0d", tag, i), 32'(b3.o_w_busy), 32'd1);
      check($sformatf("%s_idx%0d", tag, i), 32'(b3.o_w_sweep_idx), 32'(i));
      check($sformatf("%s_done%0d", tag, i), 32'(b3.o_w_done), 32'd0);
      if (noisy) begin
        b3.i_w_start    = 1'($urandom_range(0, 1));
        b3.i_w_load     = 1'($urandom_range(0, 1));
        b3.i_w_lut_data = 8'($urandom);
        b3.i_w_in       = 3'($urandom);
      end
      tick();
      check($sformatf("%s_out%0d", tag, i), 32'(b3.o_w_out), 32'(lut[i]));
    end
    b3.i_w_start = noisy;
    b3.i_w_load  = 1'b0;
    check({tag, "_done"}, 32'(b3.o_w_done), 32'd1);
    check({tag, "_busy_off"}, 32'(b3.o_w_busy), 32'd0);
    check({tag, "_count"}, 32'(b3.o_w_ones_count), 32'(exp_cnt));
    check({tag, "_idx_wrap"}, 32'(b3.o_w_sweep_idx), 32'd0);
    tick();
    b3.i_w_start = 1'b0;
    check({tag, "_done_pulse"}, 32'(b3.o_w_done), 32'd0);
    check({tag, "_idle"}, 32'(b3.o_w_busy), 32'd0);
    check({tag, "_count_hold"}, 32'(b3.o_w_ones_count), 32'(exp_cnt));
  endtask

  task automatic load3(input logic [7:0] data);
    b3.i_w_load     = 1'b1;
    b3.i_w_lut_data = data;
    tick();
    b3.i_w_load     = 1'b0;
  endtask

  task automatic eval3(input string tag, input logic [2:0] in, input logic exp);
    b3.i_w_in = in;
    tick();
    check(tag, 32'(b3.o_w_out), 32'(exp));
  endtask

  initial begin
    logic [7:0]  maj;
    int          busy_cycles;
    int          done_pulses;
    int          max_idx;
    maj = 8'hE8;

    b3.i_w_in = '0;  b3.i_w_load = 1'b0; b3.i_w_lut_data = '0; b3.i_w_start = 1'b0;
    b4.i_w_in = '0;  b4.i_w_load = 1'b0; b4.i_w_lut_data = '0; b4.i_w_start = 1'b0;

    // Reset state
    #12;
    check("rst_out", 32'(b3.o_w_out), 32'd0);
    check("rst_busy", 32'(b3.o_w_busy), 32'd0);
    check("rst_done", 32'(b3.o_w_done), 32'd0);
    check("rst_count", 32'(b3.o_w_ones_count), 32'd0);
    check("rst_idx", 32'(b3.o_w_sweep_idx), 32'd0);
    check("rst4_busy", 32'(b4.o_w_busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Majority evaluation, one cycle latency
    for (int k = 0; k < 8; k++)
      eval3($sformatf("maj_in%0d", k), 3'(k), maj[k]);

    run_sweep("maj", 8'hE8, 4, 1'b0);

    load3(8'h80);
    run_sweep("and3", 8'h80, 1, 1'b0);
    load3(8'hFF);
    run_sweep("all1", 8'hFF, 8, 1'b0);

    // Load uses the old table on its own edge: old FF[0]=1, new 96[0]=0
    b3.i_w_in = 3'd0;
    load3(8'h96);
    check("load_old_lut", 32'(b3.o_w_out), 32'd1);
    eval3("xor_in7", 3'd7, 1'b1);
    eval3("xor_in3", 3'd3, 1'b0);
    eval3("xor_in1", 3'd1, 1'b1);

    // Start wins over load: sweep runs on 96, the 00 table is dropped
    b3.i_w_load     = 1'b1;
    b3.i_w_lut_data = 8'h00;
    run_sweep("start_load", 8'h96, 4, 1'b0);
    eval3("load_dropped", 3'd7, 1'b1);

    // Abort mid-sweep by reset
    b3.i_w_start = 1'b1;
    tick();
    b3.i_w_start = 1'b0;
    tick(); tick(); tick();
    check("pre_abort_busy", 32'(b3.o_w_busy), 32'd1);
    check("pre_abort_out", 32'(b3.o_w_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_out", 32'(b3.o_w_out), 32'd0);
    check("abort_busy", 32'(b3.o_w_busy), 32'd0);
    check("abort_idx", 32'(b3.o_w_sweep_idx), 32'd0);
    check("abort_count", 32'(b3.o_w_ones_count), 32'd0);
    check("abort_done", 32'(b3.o_w_done), 32'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("abort_no_done%0d", c), 32'(b3.o_w_done), 32'd0);
    end
    eval3("lut_reinit_in3", 3'd3, 1'b1);
    eval3("lut_reinit_in4", 3'd4, 1'b0);

    // Inputs toggled during the sweep and start held in DONE are ignored
    run_sweep("noisy", 8'hE8, 4, 1'b1);
    b3.i_w_load = 1'b0;
    b3.i_w_start = 1'b0;
    eval3("noisy_lut_kept", 3'd6, 1'b1);
    check("noisy_idle", 32'(b3.o_w_busy), 32'd0);

    // 4-input build, table 8117: six ones, busy for 16 cycles
    b4.i_w_in = 4'd15;
    tick();
    check("n4_in15", 32'(b4.o_w_out), 32'd1);
    b4.i_w_in = 4'd3;
    tick();
    check("n4_in3", 32'(b4.o_w_out), 32'd0);
    b4.i_w_start = 1'b1;
    tick();
    b4.i_w_start = 1'b0;
    busy_cycles = 0;
    done_pulses = 0;
    max_idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (b4.o_w_busy) busy_cycles++;
      if (b4.o_w_done) begin
        done_pulses++;
        check("n4_count", 32'(b4.o_w_ones_count), 32'd6);
      end
      if (int'(b4.o_w_sweep_idx) > max_idx) max_idx = int'(b4.o_w_sweep_idx);
      tick();
    end
    check("n4_busy_cycles", 32'(busy_cycles), 32'd16);
    check("n4_done_pulses", 32'(done_pulses), 32'd1);
    check("n4_max_idx", 32'(max_idx), 32'd15);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
